// File: rtl/px_stream_pkg.sv
// Shared defaults and types for the pixel stream drain.
package px_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_FRAME_SIZE = 64;

    typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

    // Counter width for a modulo-n count; never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/px_fifo.sv
// First-word fall-through pixel buffer: memory, pointers and occupancy count.
// Writes are only taken while the registered count shows free space, so a
// full buffer refuses a push even when a pop happens on the same edge.
module px_fifo
    import px_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_space,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_en,
    output logic                  pop
);

    localparam int unsigned PtrWidth = cnt_width(FIFO_DEPTH);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    // Flags depend on the registered count only.
    always_comb begin
        wr_space = (count_q < DepthCnt);
        rd_valid = (count_q != '0);
        rd_data  = mem_q[rd_ptr_q];
        do_push  = wr_en & wr_space;
        do_pop   = rd_en & rd_valid;
        pop      = do_pop;
    end

    // Next-state for pointers and occupancy; power-of-two depth wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/px_stream_drain.sv
// Dataflow-to-AXI-Stream drain: buffers pixels and frames them with tlast.
// Optional macro PX_OVF_DETECT_EN adds the sticky overflow_err port.
module px_stream_drain
    import px_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned FRAME_SIZE = DEF_FRAME_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_wr,
    output logic                  in_full,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
`ifdef PX_OVF_DETECT_EN
    output logic                  frame_done,
    output logic                  overflow_err
`else
    output logic                  frame_done
`endif
);

    localparam int unsigned BeatWidth = cnt_width(FRAME_SIZE);
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(FRAME_SIZE - 1);

    logic                 pop;
    logic [BeatWidth-1:0] beat_cnt_q, beat_cnt_d;
    logic                 frame_done_q, frame_done_d;

    // in_full is "space available" in the dataflow convention.
    px_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_data  (in_data),
        .wr_en    (in_wr),
        .wr_space (in_full),
        .rd_data  (m_tdata),
        .rd_valid (m_tvalid),
        .rd_en    (m_tready),
        .pop      (pop)
    );

    // Frame position, tlast and the frame-complete pulse.
    always_comb begin
        m_tlast      = m_tvalid && (beat_cnt_q == LastBeat);
        beat_cnt_d   = beat_cnt_q;
        if (pop) beat_cnt_d = (beat_cnt_q == LastBeat) ? '0 : beat_cnt_q + 1'b1;
        frame_done_d = pop && m_tlast;
        frame_done   = frame_done_q;
    end

    // Beat counter and frame_done registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef PX_OVF_DETECT_EN
    logic ovf_q;

    // Sticky flag for any write offered while no space was available.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (in_wr && !in_full) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_err = ovf_q;
`endif

endmodule

// File: tb/tb_px_stream_drain.sv
// Directed bench for px_stream_drain (default frame and a FRAME_SIZE=1 copy).
module tb_px_stream_drain;

    logic       clock = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] in_data = '0;
    logic       in_wr = 1'b0;
    logic       in_full;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic       m_tlast;
    logic       frame_done;

    logic [7:0] in_data1 = '0;
    logic       in_wr1 = 1'b0;
    logic       in_full1;
    logic [7:0] m_tdata1;
    logic       m_tvalid1;
    logic       m_tready1 = 1'b0;
    logic       m_tlast1;
    logic       frame_done1;

`ifdef PX_OVF_DETECT_EN
    logic       overflow_err;
    logic       overflow_err1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    px_stream_drain u_dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_wr        (in_wr),
        .in_full      (in_full),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
`ifdef PX_OVF_DETECT_EN
        .frame_done   (frame_done),
        .overflow_err (overflow_err)
`else
        .frame_done   (frame_done)
`endif
    );

    px_stream_drain #(
        .FRAME_SIZE (1)
    ) u_dut1 (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data1),
        .in_wr        (in_wr1),
        .in_full      (in_full1),
        .m_tdata      (m_tdata1),
        .m_tvalid     (m_tvalid1),
        .m_tready     (m_tready1),
        .m_tlast      (m_tlast1),
`ifdef PX_OVF_DETECT_EN
        .frame_done   (frame_done1),
        .overflow_err (overflow_err1)
`else
        .frame_done   (frame_done1)
`endif
    );

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({in_full, m_tvalid, m_tlast, frame_done} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got full/valid/last/done=%b exp=1000",
                     {in_full, m_tvalid, m_tlast, frame_done});
        end
        checks++;
        if (m_tdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_tdata got=%h exp=00", m_tdata);
        end
`ifdef PX_OVF_DETECT_EN
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=0", overflow_err);
        end
`endif
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    // Push n pixels base..base+n-1 with ready high; tlast only on the 64th.
    task automatic run_frame(input logic [7:0] base, input int n, input string tag);
        int lasts = 0;
        m_tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_wr   = 1'b1;
            in_data = base + 8'(i);
            step();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== base + 8'(i)) begin
                failures++;
                $display("FAIL %s_data i=%0d got valid=%b data=%h exp valid=1 data=%h",
                         tag, i, m_tvalid, m_tdata, base + 8'(i));
            end
            checks++;
            if (m_tlast !== (i == 63) || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL %s_last i=%0d got last=%b done=%b exp last=%b done=0",
                         tag, i, m_tlast, frame_done, (i == 63));
            end
            if (m_tlast === 1'b1) lasts++;
        end
        in_wr = 1'b0;
        step();
        checks++;
        if (frame_done !== 1'b1 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse got done=%b valid=%b exp done=1 valid=0",
                     tag, frame_done, m_tvalid);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || lasts != 1) begin
            failures++;
            $display("FAIL %s_done_once got done=%b lasts=%0d exp done=0 lasts=1",
                     tag, frame_done, lasts);
        end
    endtask

    task automatic test_stream();
        run_frame(8'h00, 64, "stream");
    endtask

    task automatic test_overflow();
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_wr   = 1'b1;
            in_data = 8'hA0 + 8'(i);
            step();
            checks++;
            if (in_full !== (i < 3)) begin
                failures++;
                $display("FAIL ovf_in_full push=%0d got=%b exp=%b", i, in_full, (i < 3));
            end
        end
        in_data = 8'hAA;
        step();
        checks++;
        if (in_full !== 1'b0 || m_tdata !== 8'hA0) begin
            failures++;
            $display("FAIL ovf_drop got full=%b head=%h exp full=0 head=a0", in_full, m_tdata);
        end
`ifdef PX_OVF_DETECT_EN
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got=%b exp=1", overflow_err);
        end
`endif
    endtask

    // Continues from the full buffer left by test_overflow.
    task automatic test_full_refuse();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hA2;
        exp_seq[1] = 8'hA3;
        exp_seq[2] = 8'h55;
        exp_seq[3] = 8'h00;
        m_tready = 1'b1;
        in_wr    = 1'b1;
        in_data  = 8'h55;
        step();
        checks++;
        if (m_tdata !== 8'hA1 || in_full !== 1'b1) begin
            failures++;
            $display("FAIL refuse_first got head=%h full=%b exp head=a1 full=1", m_tdata, in_full);
        end
        step();
        in_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_tvalid !== (i < 3) || (i < 3 && m_tdata !== exp_seq[i])) begin
                failures++;
                $display("FAIL refuse_drain i=%0d got valid=%b data=%h exp valid=%b data=%h",
                         i, m_tvalid, m_tdata, (i < 3), exp_seq[i]);
            end
            step();
        end
    endtask

    task automatic test_toggle_ready();
        logic [7:0] exp_seq [3];
        logic [7:0] held_data;
        logic       held_last;
        logic       stalled;
        int         idx = 0;
        exp_seq[0] = 8'h10;
        exp_seq[1] = 8'h11;
        exp_seq[2] = 8'h12;
        for (int c = 0; c < 8; c++) begin
            in_wr    = (c < 3);
            in_data  = 8'h10 + 8'(c);
            m_tready = c[0];
            stalled  = m_tvalid && !m_tready;
            held_data = m_tdata;
            held_last = m_tlast;
            if (m_tvalid && m_tready) begin
                checks++;
                if (idx > 2 || m_tdata !== exp_seq[idx] || m_tlast !== 1'b0) begin
                    failures++;
                    $display("FAIL toggle_order c=%0d idx=%0d got data=%h last=%b", c, idx,
                             m_tdata, m_tlast);
                end
                idx++;
            end
            step();
            if (stalled) begin
                checks++;
                if (m_tdata !== held_data || m_tlast !== held_last) begin
                    failures++;
                    $display("FAIL toggle_stable c=%0d got data=%h last=%b exp data=%h last=%b",
                             c, m_tdata, m_tlast, held_data, held_last);
                end
            end
        end
        in_wr = 1'b0;
        checks++;
        if (idx != 3) begin
            failures++;
            $display("FAIL toggle_count got=%0d exp=3", idx);
        end
    endtask

    // Beats so far: 64 + 5 + 3 = 72, i.e. 8 into the current frame.
    task automatic test_reset_mid_frame();
        m_tready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            in_wr   = 1'b1;
            in_data = 8'(i);
            step();
        end
        m_tready = 1'b0;
        in_data  = 8'h77;
        step();
        step();
        in_wr = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({in_full, m_tvalid, m_tlast, frame_done} !== 4'b1000 || m_tdata !== 8'h00) begin
            failures++;
            $display("FAIL midreset_async got full/valid/last/done=%b data=%h exp 1000 data=00",
                     {in_full, m_tvalid, m_tlast, frame_done}, m_tdata);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
`ifdef PX_OVF_DETECT_EN
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ovf got=%b exp=0", overflow_err);
        end
`endif
        run_frame(8'h80, 64, "after_reset");
    endtask

    task automatic test_frame_size_one();
        m_tready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_wr1   = 1'b1;
            in_data1 = 8'h01 + 8'(i);
            step();
            checks++;
            if (m_tvalid1 !== 1'b1 || m_tlast1 !== 1'b1 || m_tdata1 !== 8'h01 + 8'(i)
                || frame_done1 !== (i > 0)) begin
                failures++;
                $display("FAIL fs1_beat i=%0d got valid=%b last=%b data=%h done=%b exp 1 1 %h %b",
                         i, m_tvalid1, m_tlast1, m_tdata1, frame_done1, 8'h01 + 8'(i), (i > 0));
            end
        end
        in_wr1 = 1'b0;
        step();
        checks++;
        if (frame_done1 !== 1'b1 || m_tlast1 !== 1'b0) begin
            failures++;
            $display("FAIL fs1_final_done got done=%b last=%b exp done=1 last=0",
                     frame_done1, m_tlast1);
        end
        step();
        checks++;
        if (frame_done1 !== 1'b0) begin
            failures++;
            $display("FAIL fs1_done_clear got=%b exp=0", frame_done1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_refuse();
        test_toggle_ready();
        test_reset_mid_frame();
        test_frame_size_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
